imgproc_frame_ctrl: RTL and testbench
=====================================

Name: imgproc_frame_ctrl

Overview:
Frame-level sequencer for the IMGPROC Bayer/RGB datapath.
- Tracks the iX_Cont/iY_Cont/iDVAL pixel stream and detects frame start, line start and frame end.
- Checks that coordinates arrive in raster order and flags sequence errors.
- Applies processing-mode changes only at frame boundaries, after a pipeline drain, so IMGPROC never processes a frame with mixed configuration.

Parameters:
FRAME_W, 640, active pixels per line
FRAME_H, 480, active lines per frame
PIPE_DEPTH, 4, IMGPROC pipeline latency in cycles; drain length after frame end
CNT_W, 16, width of frame and error counters

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous active-low reset
iDVAL  in  1  pixel valid; a pixel is accepted on a rising iCLK edge with iDVAL=1
iX_Cont  in  11  column of the current pixel
iY_Cont  in  11  row of the current pixel
iMODE_REQ  in  2  requested mode (imgproc_pkg mode_t)
iMODE_REQ_VLD  in  1  one-cycle request strobe
oMODE  out  2  applied mode, driven to IMGPROC
oMODE_PEND  out  1  a request is latched and not yet applied
oFRAME_START  out  1  one-cycle pulse
oLINE_START  out  1  one-cycle pulse
oFRAME_END  out  1  one-cycle pulse
oFLUSH  out  1  high during drain
oBUSY  out  1  state != IDLE
oSEQ_ERR  out  1  one-cycle pulse on a raster violation
oERR_CNT  out  CNT_W  saturating count of sequence errors
oFRAME_CNT  out  CNT_W  completed frames; wraps
oPIX_CNT  out  22  pixels in the last completed frame (optional feature)

Behaviour:
- Reset (iRST=0, asynchronous): state=IDLE, oMODE=MODE_RAW, all pulses/flags 0, all counters 0, expected coordinate (0,0).
- All outputs are registered. Pulses appear one cycle after the edge that accepts the triggering pixel.
- States:
  - IDLE: wait for an accepted pixel at (0,0). On it: assert oFRAME_START and oLINE_START, go to ACTIVE, expected coordinate = (1,0). Pixels at any other coordinate are ignored and are not errors.
  - ACTIVE: each accepted pixel must equal the expected (x,y).
    - Expected advances: x+1; at x=FRAME_W-1 it wraps to (0,y+1).
    - Accepted pixel with x=0 and y>0 asserts oLINE_START.
    - Accepted pixel at (FRAME_W-1,FRAME_H-1): assert oFRAME_END, oFRAME_CNT+1, go to DRAIN with drain counter = PIPE_DEPTH.
  - DRAIN: oFLUSH=1; the counter decrements each cycle. At 0, apply any pending mode (oMODE<=pending, oMODE_PEND<=0) and go to IDLE.
- Mismatch in ACTIVE:
  - oSEQ_ERR pulses and oERR_CNT increments, saturating at all-ones.
  - If the offending pixel is (0,0), it restarts the frame (oFRAME_START, stay in ACTIVE, expected (1,0)).
  - Otherwise go to IDLE with no drain and no frame count. oMODE is unchanged; the pending request is retained.
- Accepted pixel at (0,0) during DRAIN: drain is cut short. Apply the pending mode on that same edge, assert oFRAME_START, go to ACTIVE.
- Mode requests:
  - iMODE_REQ_VLD latches iMODE_REQ into pending and sets oMODE_PEND. Last request wins.
  - In IDLE, pending is applied on the next edge.
  - A request on the same edge as an apply is not lost: the new value stays pending and oMODE_PEND stays 1.
  - oMODE never changes in ACTIVE.
- iDVAL=0: no state progress in IDLE/ACTIVE; the DRAIN counter still counts.
- Coordinates beyond FRAME_W/FRAME_H in ACTIVE are mismatches.

Optional Feature:
IMGPROC_CTRL_STATS_EN
- Defined: an internal 22-bit counter counts accepted pixels in ACTIVE, including the frame-start pixel. At frame end, oPIX_CNT latches the total (FRAME_W*FRAME_H on a clean frame). The counter resets on each frame start and on error.
- Undefined: oPIX_CNT is tied to 0 and no counter is synthesized. The port exists in both builds.

Decomposition:
- imgproc_pkg holds:
  - mode_t enum: MODE_RAW=0, MODE_GRAY=1, MODE_SOBEL_H=2, MODE_SOBEL_V=3.
  - ctrl_state_t enum: IDLE, ACTIVE, DRAIN.
  - Coordinate width constant COORD_W=11.
- One sub-module, imgproc_coord_tracker:
  - Holds the expected-x/y counter with load/advance.
  - Outputs match, last-in-line and last-in-frame.
  - Parameterized by FRAME_W/FRAME_H.

Test Plan:
All scenarios use FRAME_W=8, FRAME_H=6, PIPE_DEPTH=4 and a 10 ns clock.
- Reset then a clean raster of 48 pixels, values 0x001..0x030 -> one oFRAME_START, 6 oLINE_START, oFRAME_END one cycle after pixel (7,5), oFLUSH high exactly 4 cycles, oFRAME_CNT=1, oSEQ_ERR never asserted. With the optional feature, oPIX_CNT=48.
- Request MODE_GRAY at pixel (3,2) -> oMODE_PEND=1, oMODE stays RAW for the whole frame, becomes GRAY at drain end, oMODE_PEND=0.
- Two frames back to back with (0,0) arriving 1 cycle after frame end and a pending MODE_SOBEL_H -> drain cut short, oMODE=SOBEL_H on the frame-start edge, oFRAME_CNT=2 at end.
- Skip pixel (4,1) -> oSEQ_ERR pulse, oERR_CNT=1, state IDLE. The next (0,0) starts a frame normally and oFRAME_CNT does not increment for the bad frame.
- Deassert iRST mid-frame at pixel (5,3) -> all outputs return to reset values asynchronously. oMODE=RAW and the pending request is cleared. Recovery occurs on the next (0,0).
- iMODE_REQ_VLD asserted on the drain-end apply edge with MODE_SOBEL_V while GRAY is pending -> oMODE=GRAY, SOBEL_V stays pending, and is applied in IDLE on the next edge.

Source files
------------

// File: rtl/imgproc_pkg.sv
// Shared types and constants for the IMGPROC frame controller.
package imgproc_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        MODE_RAW     = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_SOBEL_H = 2'd2,
        MODE_SOBEL_V = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } ctrl_state_t;

    // True for the raster origin, the only pixel that may open a frame.
    function automatic logic isOrigin(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
        return (x == '0) && (y == '0);
    endfunction

endpackage

// File: rtl/imgproc_coord_tracker.sv
// Expected raster coordinate for the frame controller. load primes the
// counter with the pixel after the origin; advance steps it in raster order.
module imgproc_coord_tracker
    import imgproc_pkg::*;
#(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               clr,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               match,
    output logic               lastInLine,
    output logic               lastInFrame
);

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(FRAME_H - 1);

    logic [COORD_W-1:0] expX;
    logic [COORD_W-1:0] expY;

    assign match       = (x == expX) && (y == expY);
    assign lastInLine  = (expX == LAST_X);
    assign lastInFrame = lastInLine && (expY == LAST_Y);

    // Expected-coordinate counter; out-of-frame coordinates can never match.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            expX <= '0;
            expY <= '0;
        end else if (clr) begin
            expX <= '0;
            expY <= '0;
        end else if (load) begin
            expX <= COORD_W'(1);
            expY <= '0;
        end else if (advance) begin
            if (lastInLine) begin
                expX <= '0;
                expY <= lastInFrame ? '0 : expY + 1'b1;
            end else begin
                expX <= expX + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imgproc_frame_ctrl.sv
// Frame-level sequencer for the IMGPROC datapath: raster tracking, sequence
// error detection and frame-boundary mode switching after a pipeline drain.
// Optional macro IMGPROC_CTRL_STATS_EN adds a per-frame pixel counter on
// oPIX_CNT; without it oPIX_CNT is tied to zero.
module imgproc_frame_ctrl
    import imgproc_pkg::*;
#(
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int PIPE_DEPTH = 4,    // must be at least 1
    parameter int CNT_W      = 16
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iDVAL,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    input  logic [1:0]         iMODE_REQ,
    input  logic               iMODE_REQ_VLD,
    output logic [1:0]         oMODE,
    output logic               oMODE_PEND,
    output logic               oFRAME_START,
    output logic               oLINE_START,
    output logic               oFRAME_END,
    output logic               oFLUSH,
    output logic               oBUSY,
    output logic               oSEQ_ERR,
    output logic [CNT_W-1:0]   oERR_CNT,
    output logic [CNT_W-1:0]   oFRAME_CNT,
    output logic [21:0]        oPIX_CNT
);

    localparam int DRAIN_W = (PIPE_DEPTH < 2) ? 1 : $clog2(PIPE_DEPTH + 1);

    ctrl_state_t        state, stateNext;
    logic               origin;
    logic               trkMatch, trkLastInLine, trkLastInFrame;
    logic               trkLoad, trkAdv, trkClr;
    logic               lineWrapped;
    logic               fsNext, lsNext, feNext, seNext;
    logic               applyMode;
    logic [DRAIN_W-1:0] drainCnt;
    mode_t              modeQ, pendMode;
    logic               modePend;
    logic               fsQ, lsQ, feQ, seQ, flushQ, busyQ;
    logic [CNT_W-1:0]   errCntQ, frameCntQ;

    assign origin = iDVAL && isOrigin(iX_Cont, iY_Cont);

    imgproc_coord_tracker #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H)
    ) uTracker (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .clr         (trkClr),
        .load        (trkLoad),
        .advance     (trkAdv),
        .x           (iX_Cont),
        .y           (iY_Cont),
        .match       (trkMatch),
        .lastInLine  (trkLastInLine),
        .lastInFrame (trkLastInFrame)
    );

    // State register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state, event pulses and tracker/mode controls.
    always_comb begin
        stateNext = state;
        trkLoad   = 1'b0;
        trkAdv    = 1'b0;
        trkClr    = 1'b0;
        fsNext    = 1'b0;
        lsNext    = 1'b0;
        feNext    = 1'b0;
        seNext    = 1'b0;
        applyMode = 1'b0;
        case (state)
            IDLE: begin
                applyMode = 1'b1;
                if (origin) begin
                    stateNext = ACTIVE;
                    trkLoad   = 1'b1;
                    fsNext    = 1'b1;
                    lsNext    = 1'b1;
                end
            end
            ACTIVE: begin
                if (iDVAL) begin
                    if (trkMatch) begin
                        trkAdv = 1'b1;
                        lsNext = lineWrapped;
                        if (trkLastInFrame) begin
                            feNext    = 1'b1;
                            stateNext = DRAIN;
                        end
                    end else begin
                        seNext = 1'b1;
                        if (origin) begin
                            // A fresh origin resynchronises without leaving ACTIVE.
                            trkLoad = 1'b1;
                            fsNext  = 1'b1;
                            lsNext  = 1'b1;
                        end else begin
                            stateNext = IDLE;
                            trkClr    = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (origin) begin
                    // Next frame already arriving: cut the drain short.
                    applyMode = 1'b1;
                    stateNext = ACTIVE;
                    trkLoad   = 1'b1;
                    fsNext    = 1'b1;
                    lsNext    = 1'b1;
                end else if (drainCnt == DRAIN_W'(1)) begin
                    applyMode = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Remembers that the last accepted pixel closed a line, so the next
    // matching pixel opens one.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)                  lineWrapped <= 1'b0;
        else if (trkLoad || trkClr) lineWrapped <= 1'b0;
        else if (trkAdv)            lineWrapped <= trkLastInLine;
    end

    // Drain counter: loaded at frame end, counts down while draining.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)
            drainCnt <= '0;
        else if (feNext)
            drainCnt <= DRAIN_W'(PIPE_DEPTH);
        else if (state == DRAIN && drainCnt != '0)
            drainCnt <= drainCnt - 1'b1;
    end

    // Mode request latch and boundary apply; a request on the apply edge
    // stays pending instead of being dropped.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            modeQ    <= MODE_RAW;
            pendMode <= MODE_RAW;
            modePend <= 1'b0;
        end else begin
            if (applyMode && modePend)
                modeQ <= pendMode;
            if (iMODE_REQ_VLD) begin
                pendMode <= mode_t'(iMODE_REQ);
                modePend <= 1'b1;
            end else if (applyMode) begin
                modePend <= 1'b0;
            end
        end
    end

    // Registered pulses, status flags and counters.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fsQ       <= 1'b0;
            lsQ       <= 1'b0;
            feQ       <= 1'b0;
            seQ       <= 1'b0;
            flushQ    <= 1'b0;
            busyQ     <= 1'b0;
            errCntQ   <= '0;
            frameCntQ <= '0;
        end else begin
            fsQ    <= fsNext;
            lsQ    <= lsNext;
            feQ    <= feNext;
            seQ    <= seNext;
            flushQ <= (stateNext == DRAIN);
            busyQ  <= (stateNext != IDLE);
            if (feNext)
                frameCntQ <= frameCntQ + 1'b1;
            if (seNext && errCntQ != '1)
                errCntQ <= errCntQ + 1'b1;
        end
    end

`ifdef IMGPROC_CTRL_STATS_EN
    logic [21:0] pixAcc, pixLast;

    // Pixels accepted in the current frame; total latched at frame end.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pixAcc  <= '0;
            pixLast <= '0;
        end else begin
            if (fsNext)      pixAcc <= 22'd1;
            else if (seNext) pixAcc <= '0;
            else if (trkAdv) pixAcc <= pixAcc + 1'b1;
            if (feNext)      pixLast <= pixAcc + 1'b1;
        end
    end

    assign oPIX_CNT = pixLast;
`else
    assign oPIX_CNT = '0;
`endif

    assign oMODE        = modeQ;
    assign oMODE_PEND   = modePend;
    assign oFRAME_START = fsQ;
    assign oLINE_START  = lsQ;
    assign oFRAME_END   = feQ;
    assign oFLUSH       = flushQ;
    assign oBUSY        = busyQ;
    assign oSEQ_ERR     = seQ;
    assign oERR_CNT     = errCntQ;
    assign oFRAME_CNT   = frameCntQ;

endmodule

// File: tb/tb_imgproc_frame_ctrl.sv
// Scoreboard bench for imgproc_frame_ctrl: a pixel-index reference model
// predicts every output event; a negedge monitor pops and compares them.
module tb_imgproc_frame_ctrl;
    import imgproc_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PD = 4;
    localparam int CW = 16;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iDVAL = 1'b0;
    logic [10:0] iX_Cont = '0, iY_Cont = '0;
    logic [1:0]  iMODE_REQ = '0;
    logic        iMODE_REQ_VLD = 1'b0;
    logic [1:0]  oMODE;
    logic        oMODE_PEND, oFRAME_START, oLINE_START, oFRAME_END;
    logic        oFLUSH, oBUSY, oSEQ_ERR;
    logic [CW-1:0] oERR_CNT, oFRAME_CNT;
    logic [21:0] oPIX_CNT;

    imgproc_frame_ctrl #(.FRAME_W(W), .FRAME_H(H), .PIPE_DEPTH(PD), .CNT_W(CW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iMODE_REQ(iMODE_REQ), .iMODE_REQ_VLD(iMODE_REQ_VLD), .oMODE(oMODE),
        .oMODE_PEND(oMODE_PEND), .oFRAME_START(oFRAME_START), .oLINE_START(oLINE_START),
        .oFRAME_END(oFRAME_END), .oFLUSH(oFLUSH), .oBUSY(oBUSY), .oSEQ_ERR(oSEQ_ERR),
        .oERR_CNT(oERR_CNT), .oFRAME_CNT(oFRAME_CNT), .oPIX_CNT(oPIX_CNT)
    );

    always #5 iCLK = ~iCLK;

    int tick = 0;
    always @(posedge iCLK) tick <= tick + 1;

    typedef struct {
        int stamp;
        bit fs, ls, fe, se, flush, busy;
        bit [1:0] mode;
        bit pend;
        int fcnt, ecnt, pix;
    } ev_t;

    ev_t sbq[$];
    int nChecks = 0, nPass = 0;

    // Reference model state (pixels tracked as a linear raster index).
    int mState, nextIdx, drainLeft, pixAcc, pixOut, mFcnt, mEcnt;
    bit [1:0] mMode, mPendVal, pMode;
    bit mPend, pFlush, pPend;

    task automatic model_reset();
        mState = 0; nextIdx = 0; drainLeft = 0; pixAcc = 0; pixOut = 0;
        mFcnt = 0; mEcnt = 0; mMode = 2'd0; mPendVal = 2'd0; mPend = 1'b0;
        pFlush = 1'b0; pMode = 2'd0; pPend = 1'b0;
    endtask

    task automatic model_step(input bit dv, input int x, input int y,
                              input bit rv, input bit [1:0] rq, input int stamp);
        ev_t e;
        bit apply, st, origin, inR;
        int idx;
        apply = 0; st = 0;
        origin = dv && x == 0 && y == 0;
        inR = x < W && y < H;
        idx = y * W + x;
        e.fs = 0; e.ls = 0; e.fe = 0; e.se = 0;
        case (mState)
            0: begin
                apply = 1;
                if (origin) st = 1;
            end
            1: if (dv) begin
                if (inR && idx == nextIdx) begin
                    pixAcc++;
                    if (x == 0) e.ls = 1;
                    if (idx == W * H - 1) begin
                        e.fe = 1; mFcnt = (mFcnt + 1) % 65536; pixOut = pixAcc;
                        mState = 2; drainLeft = PD;
                    end else nextIdx++;
                end else begin
                    e.se = 1;
                    if (mEcnt < 65535) mEcnt++;
                    if (origin) st = 1;
                    else begin mState = 0; pixAcc = 0; end
                end
            end
            default: begin
                drainLeft--;
                if (origin) begin apply = 1; st = 1; end
                else if (drainLeft == 0) begin apply = 1; mState = 0; end
            end
        endcase
        if (st) begin mState = 1; nextIdx = 1; pixAcc = 1; e.fs = 1; e.ls = 1; end
        if (apply && mPend) begin mMode = mPendVal; mPend = 0; end
        if (rv) begin mPendVal = rq; mPend = 1; end
        e.stamp = stamp; e.flush = (mState == 2); e.busy = (mState != 0);
        e.mode = mMode; e.pend = mPend; e.fcnt = mFcnt; e.ecnt = mEcnt;
`ifdef IMGPROC_CTRL_STATS_EN
        e.pix = pixOut;
`else
        e.pix = 0;
`endif
        if (e.fs || e.ls || e.fe || e.se || e.flush != pFlush || e.mode != pMode || e.pend != pPend)
            sbq.push_back(e);
        pFlush = e.flush; pMode = e.mode; pPend = e.pend;
    endtask

    // One clock of stimulus; entered just after a negedge.
    task automatic step(input bit dv, input int x, input int y,
                        input bit rv = 1'b0, input bit [1:0] rq = 2'd0);
        int t;
        t = tick;
        iDVAL = dv; iX_Cont = 11'(x); iY_Cont = 11'(y);
        iMODE_REQ_VLD = rv; iMODE_REQ = rq;
        @(posedge iCLK);
        model_step(dv, x, y, rv, rq, t + 1);
        @(negedge iCLK);
        iDVAL = 1'b0; iMODE_REQ_VLD = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    // Raster frame: optional skipped index, request index, random idle gaps,
    // and early stop after stopIdx pixels.
    task automatic frame(input int skipIdx, input int reqIdx, input bit [1:0] reqMode,
                         input bit gaps, input int stopIdx = W * H);
        for (int idx = 0; idx < stopIdx; idx++) begin
            if (gaps && $urandom_range(0, 3) == 0) gap(1);
            if (idx != skipIdx) step(1, idx % W, idx / W, idx == reqIdx, reqMode);
        end
    endtask

    task automatic frame_rand();
        for (int idx = 0; idx < W * H; idx++) begin
            int x, y;
            bit rv;
            bit [1:0] rq;
            x = idx % W; y = idx / W;
            rv = ($urandom_range(0, 15) == 0);
            rq = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) gap(1);
            if ($urandom_range(0, 29) == 0) begin
                x = $urandom_range(0, 9); y = $urandom_range(0, 7);
            end
            step(1, x, y, rv, rq);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s got %0d expected %0d", name, got, exp);
    endtask

    // Monitor: any pulse or flush/mode/pending change is an output event.
    bit monEn = 1'b0;
    bit qFlush = 1'b0, qPend = 1'b0;
    bit [1:0] qMode = 2'd0;
    ev_t me;
    always @(negedge iCLK) begin
        if (monEn && (oFRAME_START || oLINE_START || oFRAME_END || oSEQ_ERR ||
                      oFLUSH != qFlush || oMODE != qMode || oMODE_PEND != qPend)) begin
            nChecks++;
            if (sbq.size() == 0) begin
                $display("FAIL event at cycle %0d: DUT output event, none expected", tick);
            end else begin
                me = sbq.pop_front();
                if (me.stamp == tick && me.fs == oFRAME_START && me.ls == oLINE_START &&
                    me.fe == oFRAME_END && me.se == oSEQ_ERR && me.flush == oFLUSH &&
                    me.busy == oBUSY && me.mode == oMODE && me.pend == oMODE_PEND &&
                    me.fcnt == int'(oFRAME_CNT) && me.ecnt == int'(oERR_CNT) &&
                    me.pix == int'(oPIX_CNT))
                    nPass++;
                else
                    $display("FAIL event cycle got %0d exp %0d | fs ls fe se got %b%b%b%b exp %b%b%b%b | flush busy got %b%b exp %b%b | mode pend got %0d %b exp %0d %b | fcnt got %0d exp %0d | ecnt got %0d exp %0d | pix got %0d exp %0d",
                             tick, me.stamp, oFRAME_START, oLINE_START, oFRAME_END, oSEQ_ERR,
                             me.fs, me.ls, me.fe, me.se, oFLUSH, oBUSY, me.flush, me.busy,
                             oMODE, oMODE_PEND, me.mode, me.pend, oFRAME_CNT, me.fcnt,
                             oERR_CNT, me.ecnt, oPIX_CNT, me.pix);
            end
        end
        qFlush = oFLUSH; qMode = oMODE; qPend = oMODE_PEND;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mode"}, oMODE, 0);
        chk({tag, "_pend"}, oMODE_PEND, 0);
        chk({tag, "_busy"}, oBUSY, 0);
        chk({tag, "_flush"}, oFLUSH, 0);
        chk({tag, "_pulses"}, {oFRAME_START, oLINE_START, oFRAME_END, oSEQ_ERR}, 0);
        chk({tag, "_fcnt"}, oFRAME_CNT, 0);
        chk({tag, "_ecnt"}, oERR_CNT, 0);
        chk({tag, "_pix"}, oPIX_CNT, 0);
    endtask

    initial begin
        model_reset();
        #1 iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        #1 chk_reset_vals("reset");
        @(negedge iCLK);
        iRST = 1'b1;
        #1 monEn = 1'b1;

        // Clean frame.
        frame(-1, -1, 2'd0, 1'b1);
        gap(8);
        chk("clean_fcnt", oFRAME_CNT, 1);
        chk("clean_ecnt", oERR_CNT, 0);
`ifdef IMGPROC_CTRL_STATS_EN
        chk("clean_pix", oPIX_CNT, W * H);
`endif

        // GRAY requested at (3,2), applied after the drain.
        frame(-1, 2 * W + 3, MODE_GRAY, 1'b1);
        gap(8);
        chk("gray_mode", oMODE, MODE_GRAY);
        chk("gray_pend", oMODE_PEND, 0);

        // Back-to-back frames: origin one cycle after frame end cuts the drain.
        frame(-1, 10, MODE_SOBEL_H, 1'b0);
        frame(-1, -1, 2'd0, 1'b0);
        gap(8);
        chk("b2b_mode", oMODE, MODE_SOBEL_H);
        chk("b2b_fcnt", oFRAME_CNT, 4);

        // Skipped pixel (4,1): error, back to idle, bad frame not counted.
        frame(W + 4, -1, 2'd0, 1'b0);
        chk("skip_busy", oBUSY, 0);
        chk("skip_ecnt", oERR_CNT, 1);
        frame(-1, -1, 2'd0, 1'b1);
        gap(8);
        chk("skip_fcnt", oFRAME_CNT, 5);

        // Asynchronous reset mid-frame after (5,3) with a request pending.
        frame(-1, 10, MODE_SOBEL_V, 1'b0, 3 * W + 6);
        monEn = 1'b0;
        #2 iRST = 1'b0;
        #1 chk_reset_vals("midreset");
        model_reset();
        @(negedge iCLK);
        iRST = 1'b1;
        #1 monEn = 1'b1;
        frame(-1, -1, 2'd0, 1'b1);
        gap(8);
        chk("recover_fcnt", oFRAME_CNT, 1);

        // Request on the drain-end apply edge while GRAY is pending.
        frame(-1, 20, MODE_GRAY, 1'b0);
        gap(PD - 1);
        step(0, 0, 3, 1'b1, MODE_SOBEL_V);
        chk("applyedge_mode", oMODE, MODE_GRAY);
        chk("applyedge_pend", oMODE_PEND, 1);
        gap(1);
        chk("applyedge_mode2", oMODE, MODE_SOBEL_V);
        chk("applyedge_pend2", oMODE_PEND, 0);

        // Randomized frames with corrupted coordinates and random requests.
        for (int f = 0; f < 8; f++) begin
            frame_rand();
            if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 6));
        end
        gap(10);
        chk("sbq_empty", sbq.size(), 0);
        chk("final_fcnt", oFRAME_CNT, mFcnt);
        chk("final_ecnt", oERR_CNT, mEcnt);
        chk("final_mode", oMODE, mMode);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
